// File: rtl/fft_frame_loader.sv
// Frame sequencer: fetches N samples from a handshaked source into the FFT input buffer,
// waits for fft_finish and optionally re-arms. Optional FFT watchdog: FFT_FRAME_LOADER_TIMEOUT_EN.
module fft_frame_loader #(
    parameter int N              = 32,
    parameter int SAMPLE_W       = 16,
    parameter int START_DELAY    = 4,
    parameter int GAP_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 continuous,
    input  logic [GAP_W-1:0]     gap_cycles,
    output logic [$clog2(N)-1:0] src_addr,
    input  logic                 src_valid,
    input  logic [SAMPLE_W-1:0]  sample_in,
    output logic                 fft_we,
    output logic [$clog2(N)-1:0] fft_addr,
    output logic [SAMPLE_W-1:0]  fft_data,
    input  logic                 fft_finish,
    output logic                 busy,
    output logic                 frame_start,
    output logic [15:0]          frame_count,
    output logic                 timeout_err
);

    localparam int AW    = $clog2(N);
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int CNT_W = (GAP_W > DLY_W) ? GAP_W : DLY_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    if (N < 4 || (N & (N - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fft_frame_loader: N must be a power of two >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_LOAD,
        S_WAIT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fft_we_q, fft_we_d;
    logic [AW-1:0]     fft_addr_q, fft_addr_d;
    logic [SAMPLE_W-1:0] fft_data_q, fft_data_d;
    logic              frame_start_q, frame_start_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic              tmo_hit;
    logic              frame_end;

`ifdef FFT_FRAME_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Watchdog counts WAIT_FFT cycles; a real finish always wins over expiry.
    always_comb begin
        tmo_hit = (state_q == S_WAIT) && !fft_finish && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_d   = '0;
        if (state_q == S_WAIT && !fft_finish && !tmo_hit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign frame_end = (state_q == S_WAIT) && (fft_finish || tmo_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = (START_DELAY == 0) ? S_LOAD : S_DELAY;
                end
            end
            S_DELAY, S_GAP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (src_valid && idx_q == LAST_IDX) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_end) begin
                    if (continuous && enable) begin
                        state_d = (gap_cycles != '0) ? S_GAP : S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Delay and gap share one down-counter; it is preloaded in the state before each use.
    always_comb begin
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        fft_we_d      = 1'b0;
        fft_addr_d    = fft_addr_q;
        fft_data_d    = fft_data_q;
        frame_start_d = (state_d == S_LOAD) && (state_q != S_LOAD);
        frame_count_d = frame_count_q;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: cnt_d = CNT_W'(START_DELAY - 1);
            S_DELAY, S_GAP: cnt_d = cnt_q - CNT_W'(1);
            S_LOAD: begin
                if (enable && src_valid) begin
                    fft_we_d   = 1'b1;
                    fft_addr_d = idx_q;
                    fft_data_d = sample_in;
                    idx_d      = idx_q + AW'(1);
                end
            end
            S_WAIT: begin
                cnt_d         = CNT_W'(gap_cycles) - CNT_W'(1);
                timeout_err_d = tmo_hit;
                if (fft_finish) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            default: ;
        endcase
        // Leaving LOAD, whether complete or abandoned, always restarts the next frame at 0.
        if (state_d != S_LOAD) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            cnt_q         <= '0;
            fft_we_q      <= 1'b0;
            fft_addr_q    <= '0;
            fft_data_q    <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            fft_we_q      <= fft_we_d;
            fft_addr_q    <= fft_addr_d;
            fft_data_q    <= fft_data_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign src_addr    = idx_q;
    assign fft_we      = fft_we_q;
    assign fft_addr    = fft_addr_q;
    assign fft_data    = fft_data_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader with a combinational ramp ROM as source.
module tb_fft_frame_loader;

    localparam int N           = 32;
    localparam int SAMPLE_W    = 16;
    localparam int START_DELAY = 4;
    localparam int GAP_W       = 16;
    localparam int TMO         = 16;
    localparam int AW          = $clog2(N);

    logic                clk         = 1'b0;
    logic                rst_n       = 1'b0;
    logic                enable      = 1'b0;
    logic                continuous  = 1'b0;
    logic                src_valid   = 1'b0;
    logic                fft_finish  = 1'b0;
    logic [GAP_W-1:0]    gap_cycles  = '0;
    logic [AW-1:0]       src_addr;
    logic [AW-1:0]       fft_addr;
    logic [SAMPLE_W-1:0] sample_in;
    logic [SAMPLE_W-1:0] fft_data;
    logic                fft_we;
    logic                busy;
    logic                frame_start;
    logic                timeout_err;
    logic [15:0]         frame_count;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;

    assign sample_in = SAMPLE_W'(src_addr) | 16'hA500;

    always #5 clk = ~clk;

    fft_frame_loader #(
        .N(N), .SAMPLE_W(SAMPLE_W), .START_DELAY(START_DELAY),
        .GAP_W(GAP_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .continuous(continuous),
        .gap_cycles(gap_cycles), .src_addr(src_addr), .src_valid(src_valid),
        .sample_in(sample_in), .fft_we(fft_we), .fft_addr(fft_addr),
        .fft_data(fft_data), .fft_finish(fft_finish), .busy(busy),
        .frame_start(frame_start), .frame_count(frame_count), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 200);
    endtask

    task automatic pulse_finish();
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
    endtask

    // Called in the first LOAD cycle; every cycle's write strobe must follow that cycle's valid.
    task automatic load_frame(input bit toggle, input string tag);
        int   acc = 0;
        int   cyc = 0;
        logic v;
        while (acc < N && cyc < 200) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            src_valid = v;
            check({tag, "_src_addr"}, src_addr, acc);
            step();
            cyc++;
            check({tag, "_we"}, fft_we, v);
            if (fft_we) begin
                check({tag, "_addr"}, fft_addr, acc);
                check({tag, "_data"}, fft_data, 32'h0000A500 | acc);
                acc++;
            end
        end
        src_valid = 1'b1;
        check({tag, "_nwrites"}, acc, N);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, fft_we, 0);
        check({tag, "_addr"}, fft_addr, 0);
        check({tag, "_data"}, fft_data, 0);
        check({tag, "_src_addr"}, src_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fstart"}, frame_start, 0);
        check({tag, "_fcount"}, frame_count, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    initial begin : main
        int n;
        repeat (3) step();
        check_all_zero("rst");
        rst_n = 1'b1;
        step();

        // Single frame, ROM always valid, then disarm while the FFT runs.
        enable    = 1'b1;
        src_valid = 1'b1;
        wait_start(n);
        check("t1_start_lat", n, START_DELAY + 1);
        load_frame(1'b0, "t1");
        enable = 1'b0;
        repeat (5) begin
            step();
            check("t1_wait_busy", busy, 1);
            check("t1_wait_we", fft_we, 0);
        end
        pulse_finish();
        exp_fc++;
        check("t1_fcount", frame_count, exp_fc);
        check("t1_idle", busy, 0);

        // Source stalls on every other cycle.
        enable = 1'b1;
        wait_start(n);
        check("t2_start_lat", n, START_DELAY + 1);
        load_frame(1'b1, "t2");
        enable = 1'b0;
        pulse_finish();
        exp_fc++;
        check("t2_fcount", frame_count, exp_fc);

        // Continuous mode with a 5-cycle gap.
        continuous = 1'b1;
        gap_cycles = 16'd5;
        enable     = 1'b1;
        wait_start(n);
        for (int f = 0; f < 3; f++) begin
            load_frame(1'b0, "t3");
            pulse_finish();
            exp_fc++;
            check("t3_fcount", frame_count, exp_fc);
            check("t3_gap_busy", busy, 1);
            wait_start(n);
            check("t3_restart", n + 1, 6);
        end

        // Abandon the fourth frame at idx 10, then re-arm.
        src_valid = 1'b1;
        repeat (10) step();
        check("t4_idx", src_addr, 10);
        enable = 1'b0;
        step();
        check("t4_abort_busy", busy, 0);
        check("t4_abort_idx", src_addr, 0);
        check("t4_abort_fcount", frame_count, exp_fc);
        continuous = 1'b0;
        gap_cycles = '0;
        enable     = 1'b1;
        wait_start(n);
        check("t4_rearm_lat", n, START_DELAY + 1);
        load_frame(1'b0, "t4");
        enable = 1'b0;
        pulse_finish();
        exp_fc++;
        check("t4_fcount", frame_count, exp_fc);

        // Asynchronous reset between clock edges in the middle of a frame.
        enable = 1'b1;
        wait_start(n);
        repeat (4) step();
        check("t5_we_before", fft_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        exp_fc = 0;
        enable = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        enable = 1'b1;
        wait_start(n);
        check("t5_start_lat", n, START_DELAY + 1);
        load_frame(1'b0, "t5");
        enable = 1'b0;

        // No fft_finish: watchdog behaviour.
`ifdef FFT_FRAME_LOADER_TIMEOUT_EN
        n = 0;
        do begin
            step();
            n++;
        end while (!timeout_err && n < 100);
        check("t6_tmo_lat", n, TMO);
        check("t6_tmo_fcount", frame_count, exp_fc);
        step();
        check("t6_tmo_pulse", timeout_err, 0);
        check("t6_tmo_idle", busy, 0);
`else
        n = 0;
        repeat (3000) begin
            step();
            if (timeout_err) n++;
        end
        check("t6_no_tmo", n, 0);
        check("t6_still_wait", busy, 1);
        pulse_finish();
        exp_fc++;
        check("t6_fcount", frame_count, exp_fc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
